// File: rtl/game_pkg.sv
// Shared encodings for the game flow controller: display-facing game_state codes,
// FSM state constants and the default level ceiling.
package game_pkg;

    localparam logic [1:0] GS_TITLE = 2'b00;
    localparam logic [1:0] GS_MAIN  = 2'b01;
    localparam logic [1:0] GS_LOSE  = 2'b10;
    localparam logic [1:0] GS_WIN   = 2'b11;

    localparam logic [2:0] TITLE  = 3'd0;
    localparam logic [2:0] RELOAD = 3'd1;
    localparam logic [2:0] MAIN   = 3'd2;
    localparam logic [2:0] PAUSE  = 3'd3;
    localparam logic [2:0] LOSE   = 3'd4;
    localparam logic [2:0] WIN    = 3'd5;

    localparam int MAX_LEVEL = 9;

    // PAUSE, TITLE and RELOAD all present as GS_TITLE to the display path.
    function automatic logic [1:0] gs_of(input logic [2:0] st);
        logic [1:0] gs;
        case (st)
            MAIN:    gs = GS_MAIN;
            LOSE:    gs = GS_LOSE;
            WIN:     gs = GS_WIN;
            default: gs = GS_TITLE;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/game_sequencer_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, debounced level and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch, done;

    assign mismatch = (sync2_q != level_q);
    assign done     = mismatch && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // The counter only runs while the synchronised input disagrees with the stored level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (done) begin
            level_d = sync2_q;
            press_d = sync2_q;
        end else if (mismatch) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: TITLE/RELOAD/MAIN/PAUSE/LOSE/WIN sequencing, gated player controls,
// end-screen hold/timeout and level tracking. All outputs are registered from the next state.
module game_sequencer #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int END_HOLD_CYCLES    = 25000000,
    parameter int END_TIMEOUT_CYCLES = 500000000,
    parameter int MAX_LEVEL          = game_pkg::MAX_LEVEL,
    parameter int LEVEL_W            = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_fire,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_pause,
    input  logic               game_over,
    input  logic               game_win,
    output logic [1:0]         game_state,
    output logic               logic_reset,
    output logic               fire_out,
    output logic               left_out,
    output logic               right_out,
    output logic               paused,
    output logic [LEVEL_W-1:0] level,
    output logic               level_up,
    output logic [2:0]         state_dbg
);

    import game_pkg::*;

    localparam int HOLD_W = $clog2(END_HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(END_TIMEOUT_CYCLES + 1);

    logic fire_level, fire_press, left_level, left_press;
    logic right_level, right_press, pause_level, pause_press;
    logic unused_btn;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
        .clk(clk), .reset(reset), .btn_raw(btn_fire), .level(fire_level), .press(fire_press));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn_raw(btn_left), .level(left_level), .press(left_press));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn_raw(btn_right), .level(right_level), .press(right_press));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk(clk), .reset(reset), .btn_raw(btn_pause), .level(pause_level), .press(pause_press));

    assign unused_btn = ^{fire_level, left_press, right_press, pause_level};

    logic [2:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [1:0]         gs_q;
    logic               lreset_q, fire_q, left_q, right_q, paused_q, level_up_q;
    logic               hold_full, accept, timeout, main_d;

    assign hold_full = (hold_cnt_q == HOLD_W'(END_HOLD_CYCLES));
    assign accept    = fire_press && hold_full;
    assign timeout   = (to_cnt_q == TO_W'(END_TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            TITLE:  if (fire_press) state_d = RELOAD;
            RELOAD: state_d = MAIN;
            MAIN: begin
                if (game_over)        state_d = LOSE;
                else if (game_win)    state_d = WIN;
                else if (pause_press) state_d = PAUSE;
            end
            PAUSE:  if (pause_press) state_d = MAIN;
            LOSE: begin
                if (accept || timeout) begin
                    state_d = TITLE;
                    level_d = '0;
                end
            end
            WIN: begin
                if (accept) begin
                    state_d = RELOAD;
                    if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
                end
            end
            default: state_d = TITLE;
        endcase
    end

    // End-screen counters restart on every state entry and never wrap.
    always_comb begin
        hold_cnt_d = '0;
        to_cnt_d   = '0;
        if (state_d == state_q) begin
            hold_cnt_d = hold_cnt_q;
            to_cnt_d   = to_cnt_q;
            if ((state_q == LOSE || state_q == WIN) && !hold_full)
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (state_q == LOSE && to_cnt_q != TO_W'(END_TIMEOUT_CYCLES))
                to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign main_d = (state_d == MAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TITLE;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            level_q    <= '0;
            gs_q       <= GS_TITLE;
            lreset_q   <= 1'b1;
            fire_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            paused_q   <= 1'b0;
            level_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
            level_q    <= level_d;
            gs_q       <= gs_of(state_d);
            lreset_q   <= (state_d == TITLE) || (state_d == RELOAD);
            fire_q     <= main_d && (state_q == MAIN) && fire_press;
            left_q     <= main_d && left_level && !right_level;
            right_q    <= main_d && right_level && !left_level;
            paused_q   <= (state_d == PAUSE);
            level_up_q <= (state_q == WIN) && (level_d != level_q);
        end
    end

    assign game_state  = gs_q;
    assign logic_reset = lreset_q;
    assign fire_out    = fire_q;
    assign left_out    = left_q;
    assign right_out   = right_q;
    assign paused      = paused_q;
    assign level       = level_q;
    assign level_up    = level_up_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer with short debounce/hold/timeout settings.
module tb_game_sequencer;

    localparam int LAT = 7;  // raw edge to first registered output reaction

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_fire = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_pause = 1'b0;
    logic       game_over = 1'b0, game_win = 1'b0;
    logic [1:0] game_state;
    logic       logic_reset, fire_out, left_out, right_out, paused, level_up;
    logic [3:0] level;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] fire_q[$];
    logic [35:0] lu_q[$];

    typedef struct {
        string      name;
        logic [3:0] btn;
        logic       go, gw;
        int         n;
        logic       ef, elu;
        logic [1:0] gs;
        logic       lr, pz, lo, ro;
        logic [3:0] lvl;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    game_sequencer #(
        .DEBOUNCE_CYCLES(4), .END_HOLD_CYCLES(10), .END_TIMEOUT_CYCLES(50),
        .MAX_LEVEL(2), .LEVEL_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_fire(btn_fire), .btn_left(btn_left), .btn_right(btn_right), .btn_pause(btn_pause),
        .game_over(game_over), .game_win(game_win),
        .game_state(game_state), .logic_reset(logic_reset), .fire_out(fire_out),
        .left_out(left_out), .right_out(right_out), .paused(paused),
        .level(level), .level_up(level_up), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0d expected=%0d", nm, what, act, exp);
        end
    endtask

    // Advance one cycle, then score pulse outputs against the expected-event queues.
    task automatic tick();
        logic [35:0] e;
        @(posedge clk);
        #1;
        if (fire_q.size() != 0 && cyc > int'(fire_q[0])) begin
            chk("sb", "fire_missed", cyc, fire_q.pop_front());
        end
        if (fire_out) begin
            if (fire_q.size() == 0) chk("sb", "fire_unexpected", {31'd0, fire_out}, 0);
            else chk("sb", "fire_cycle", cyc, fire_q.pop_front());
        end
        if (lu_q.size() != 0 && cyc > int'(lu_q[0][31:0])) begin
            e = lu_q.pop_front();
            chk("sb", "level_up_missed", cyc, e[31:0]);
        end
        if (level_up) begin
            if (lu_q.size() == 0) chk("sb", "level_up_unexpected", {31'd0, level_up}, 0);
            else begin
                e = lu_q.pop_front();
                chk("sb", "level_up_cycle", cyc, e[31:0]);
                chk("sb", "level_up_level", {28'd0, level}, {28'd0, e[35:32]});
            end
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] btn, input logic go, input logic gw,
                                input int n, input logic ef, input logic elu, input logic [1:0] gs,
                                input logic lr, input logic pz, input logic lo, input logic ro,
                                input logic [3:0] lvl);
        vec_t v;
        v.name = nm; v.btn = btn; v.go = go; v.gw = gw; v.n = n; v.ef = ef; v.elu = elu;
        v.gs = gs; v.lr = lr; v.pz = pz; v.lo = lo; v.ro = ro; v.lvl = lvl;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        {btn_fire, btn_left, btn_right, btn_pause} = v.btn;
        game_over = v.go;
        game_win  = v.gw;
        if (v.ef)  fire_q.push_back(32'(cyc + LAT));
        if (v.elu) lu_q.push_back({v.lvl, 32'(cyc + LAT)});
        repeat (v.n) tick();
        chk(v.name, "game_state", {30'd0, game_state}, {30'd0, v.gs});
        chk(v.name, "logic_reset", {31'd0, logic_reset}, {31'd0, v.lr});
        chk(v.name, "paused", {31'd0, paused}, {31'd0, v.pz});
        chk(v.name, "left_out", {31'd0, left_out}, {31'd0, v.lo});
        chk(v.name, "right_out", {31'd0, right_out}, {31'd0, v.ro});
        chk(v.name, "level", {28'd0, level}, {28'd0, v.lvl});
    endtask

    task automatic add_win(inout vec_t q[$], input logic [3:0] lvl, input logic elu);
        q.push_back(mk("win", 4'b0000, 0, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0, lvl - {3'd0, elu}));
        q.push_back(mk("win_hold", 4'b0000, 0, 0, 12, 0, 0, 2'b11, 0, 0, 0, 0, lvl - {3'd0, elu}));
        q.push_back(mk("win_fire", 4'b1000, 0, 0, 7, 0, elu, 2'b00, 1, 0, 0, 0, lvl));
        q.push_back(mk("win_main", 4'b1000, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, lvl));
        q.push_back(mk("win_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, lvl));
    endtask

    initial begin
        // MAIN controls, pause, then three wins with the level ceiling at 2.
        tab_a.push_back(mk("fire1", 4'b1000, 0, 0, 8, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("fire1_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("fire2", 4'b1000, 0, 0, 8, 1, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("fire2_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("left_hold", 4'b0100, 0, 0, 20, 0, 0, 2'b01, 0, 0, 1, 0, 0));
        tab_a.push_back(mk("left_right", 4'b0110, 0, 0, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("lr_rel", 4'b0000, 0, 0, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("right_hold", 4'b0010, 0, 0, 10, 0, 0, 2'b01, 0, 0, 0, 1, 0));
        tab_a.push_back(mk("right_rel", 4'b0000, 0, 0, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("pause_on", 4'b0001, 0, 0, 8, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pause_on_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pz_fire", 4'b1000, 0, 0, 8, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pz_fire_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pz_left", 4'b0100, 0, 0, 10, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pz_left_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tab_a.push_back(mk("pause_off", 4'b0001, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_a.push_back(mk("pause_off_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        add_win(tab_a, 4'd1, 1'b1);
        add_win(tab_a, 4'd2, 1'b1);
        add_win(tab_a, 4'd2, 1'b0);

        // From TITLE: win, LOSE exited by an accepted press, win, LOSE exited by timeout.
        tab_b.push_back(mk("b_start", 4'b1000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_b.push_back(mk("b_start_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        add_win(tab_b, 4'd1, 1'b1);
        tab_b.push_back(mk("lose", 4'b1000, 1, 1, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("lose_early", 4'b1000, 0, 0, 7, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("lose_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("lose_fire", 4'b1000, 0, 0, 8, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        tab_b.push_back(mk("lose_fire_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        tab_b.push_back(mk("b_restart", 4'b1000, 0, 0, 10, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tab_b.push_back(mk("b_restart_rel", 4'b0000, 0, 0, 8, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        add_win(tab_b, 4'd1, 1'b1);
        tab_b.push_back(mk("to_enter", 4'b0000, 1, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("to_wait48", 4'b0000, 0, 0, 48, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("to_wait49", 4'b0000, 0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 1));
        tab_b.push_back(mk("to_wait50", 4'b0000, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0));

        // Reset block.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset", "state", {29'd0, state_dbg}, {29'd0, game_pkg::TITLE});
        chk("reset", "game_state", {30'd0, game_state}, 0);
        chk("reset", "logic_reset", {31'd0, logic_reset}, 1);
        chk("reset", "outs", {28'd0, fire_out, left_out, right_out, paused}, 0);
        chk("reset", "level", {28'd0, level}, 0);
        chk("reset", "level_up", {31'd0, level_up}, 0);

        // A 3-cycle glitch must not start the game; a clean press goes TITLE->RELOAD->MAIN.
        btn_fire = 1'b1;
        repeat (3) tick();
        btn_fire = 1'b0;
        repeat (10) tick();
        chk("glitch", "state", {29'd0, state_dbg}, {29'd0, game_pkg::TITLE});
        chk("glitch", "logic_reset", {31'd0, logic_reset}, 1);
        btn_fire = 1'b1;
        repeat (6) tick();
        chk("start", "state_pre", {29'd0, state_dbg}, {29'd0, game_pkg::TITLE});
        tick();
        chk("start", "state_reload", {29'd0, state_dbg}, {29'd0, game_pkg::RELOAD});
        chk("start", "reload_gs", {30'd0, game_state}, 0);
        chk("start", "reload_lr", {31'd0, logic_reset}, 1);
        tick();
        chk("start", "state_main", {29'd0, state_dbg}, {29'd0, game_pkg::MAIN});
        chk("start", "main_gs", {30'd0, game_state}, 1);
        chk("start", "main_lr", {31'd0, logic_reset}, 0);
        btn_fire = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < tab_a.size(); i++) run_vec(tab_a[i]);

        // One-cycle reset while paused drops straight back to TITLE with level cleared.
        btn_pause = 1'b1;
        repeat (8) tick();
        btn_pause = 1'b0;
        repeat (8) tick();
        chk("rst_pause", "paused_pre", {31'd0, paused}, 1);
        chk("rst_pause", "level_pre", {28'd0, level}, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_pause", "state", {29'd0, state_dbg}, {29'd0, game_pkg::TITLE});
        chk("rst_pause", "paused", {31'd0, paused}, 0);
        chk("rst_pause", "logic_reset", {31'd0, logic_reset}, 1);
        chk("rst_pause", "game_state", {30'd0, game_state}, 0);
        chk("rst_pause", "level", {28'd0, level}, 0);

        for (int i = 0; i < tab_b.size(); i++) run_vec(tab_b[i]);

        repeat (10) tick();
        chk("final", "fire_q_left", fire_q.size(), 0);
        chk("final", "lu_q_left", lu_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
